fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. It owns the program counter, drives the instruction SRAM request, and hands `{ce, pc}` to decode over `if_to_id_bus`. Decode resolves branches and returns them on `br_bus`. The block applies a redirect to the fetch after the delay slot, and latches it if a stall is active so the redirect is never lost.

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_unit_branch_pending_reg.sv | 32 +++
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the stall vector encoding, bus widths, FSM states and the reset vector.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'hBFC0_0000;

  localparam int BR_WD       = 33;
  localparam int IF_TO_ID_WD = 33;
  localparam int STALL_WD    = 6;

  typedef logic [STALL_WD-1:0] StallBus;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // A fetch is misaligned when the word address has any byte-offset bits set.
  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Pipeline-facing and SRAM-facing signals of the fetch stage.
// The fetch unit uses the master view; the surrounding pipeline uses the slave view.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  StallBus                stall;
  logic [BR_WD-1:0]       br_bus;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;
  logic                   inst_sram_en;
  logic [3:0]             inst_sram_wen;
  logic [31:0]            inst_sram_addr;
  logic [31:0]            inst_sram_wdata;
  logic                   fetch_adel;
  logic [31:0]            fetch_cnt;

  modport master (
    input  stall,
    input  br_bus,
    output if_to_id_bus,
    output inst_sram_en,
    output inst_sram_wen,
    output inst_sram_addr,
    output inst_sram_wdata,
    output fetch_adel,
    output fetch_cnt
  );

  modport slave (
    output stall,
    output br_bus,
    input  if_to_id_bus,
    input  inst_sram_en,
    input  inst_sram_wen,
    input  inst_sram_addr,
    input  inst_sram_wdata,
    input  fetch_adel,
    input  fetch_cnt
  );

endinterface

// File: rtl/fetch_unit_branch_pending_reg.sv
// Remembers a branch redirect that arrived while fetch was stalled and
// selects the redirect target for the next PC (a live branch wins).
module branch_pending_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        br_e,
  input  logic [31:0] br_addr,
  output logic        redir,
  output logic [31:0] tgt
);

  logic        pend_v;
  logic [31:0] pend_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_v    <= 1'b0;
      pend_addr <= '0;
    end else if (advance) begin
      pend_v <= 1'b0;
    end else if (br_e) begin
      // The most recent branch during a hold is the one that counts.
      pend_v    <= 1'b1;
      pend_addr <= br_addr;
    end
  end

  assign redir = br_e | pend_v;
  assign tgt   = br_e ? br_addr : pend_addr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM read and
// hands {ce, pc} to decode, applying branch redirects after the delay slot.
//
// state | meaning
// BOOT  | out of reset, no fetch issued yet (ce low)
// RUN   | PC advances every cycle
// HOLD  | stall[0] asserted, PC and SRAM address frozen
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_r;
  logic        ce_r;
  logic [31:0] cnt_r;
  logic        advance;
  logic        br_e;
  logic [31:0] br_addr;
  logic        redir;
  logic [31:0] tgt;
  logic [31:0] npc;
  logic        adel;
  logic        stall_hi_unused;

  assign advance = (bus.stall[0] == NoStop);
  assign br_e    = bus.br_bus[BR_WD-1];
  assign br_addr = bus.br_bus[31:0];

  // Only the PC-hold bit of the stall vector concerns fetch.
  assign stall_hi_unused = ^bus.stall[STALL_WD-1:1];

  branch_pending_reg u_branch_pending_reg (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .br_e    (br_e),
    .br_addr (br_addr),
    .redir   (redir),
    .tgt     (tgt)
  );

  assign npc = redir ? tgt : pc_r + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    if (advance) state_d = RUN;
      RUN:     if (!advance) state_d = HOLD;
      HOLD:    if (advance) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Reset parks the PC one word before the vector so the first advance lands on it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r  <= RESET_VEC - 32'd4;
      ce_r  <= 1'b0;
      cnt_r <= '0;
    end else if (advance) begin
      pc_r <= npc;
      ce_r <= 1'b1;
      if (!misaligned(npc)) begin
        cnt_r <= cnt_r + 32'd1;
      end
    end
  end

  assign adel = ce_r & misaligned(pc_r);

  assign bus.if_to_id_bus    = {ce_r, pc_r};
  assign bus.inst_sram_en    = ce_r & ~adel;
  assign bus.inst_sram_wen   = 4'b0000;
  assign bus.inst_sram_addr  = pc_r;
  assign bus.inst_sram_wdata = 32'd0;
  assign bus.fetch_adel      = adel;
  assign bus.fetch_cnt       = cnt_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios then random stall/branch/reset
// traffic, checked against a behavioural model of PC sequencing.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RV = RESET_VEC_DEFAULT;

  logic clk = 1'b0;
  logic rst;

  fetch_unit_if bus();

  fetch_unit #(.RESET_VEC(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [32:0] id;
    logic        en;
    logic [31:0] addr;
    logic        adel;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model: PC, fetch-valid, optional pending redirect, aligned-fetch count.
  logic [31:0] m_pc, m_pa, m_cnt;
  logic        m_ce, m_pv;

  task automatic cmp(input string name, input logic [32:0] act, input logic [32:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp("if_to_id_bus", bus.if_to_id_bus, e.id);
      cmp("inst_sram_en", {32'd0, bus.inst_sram_en}, {32'd0, e.en});
      cmp("inst_sram_addr", {1'b0, bus.inst_sram_addr}, {1'b0, e.addr});
      cmp("fetch_adel", {32'd0, bus.fetch_adel}, {32'd0, e.adel});
      cmp("fetch_cnt", {1'b0, bus.fetch_cnt}, {1'b0, e.cnt});
      cmp("inst_sram_wen", {29'd0, bus.inst_sram_wen}, 33'd0);
      cmp("inst_sram_wdata", {1'b0, bus.inst_sram_wdata}, 33'd0);
    end
  end

  task automatic step(input logic r, input logic s0, input logic be, input logic [31:0] ba);
    logic [31:0] t;
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.stall    = {5'($urandom), s0};
    bus.br_bus   = {be, ba};
    @(posedge clk);
    #1;
    if (!r) begin
      m_pc = RV - 32'd4; m_ce = 1'b0; m_pv = 1'b0; m_pa = '0; m_cnt = '0;
    end else if (!s0) begin
      t = be ? ba : (m_pv ? m_pa : m_pc + 32'd4);
      m_pc = t; m_ce = 1'b1; m_pv = 1'b0;
      if (t % 4 == 0) m_cnt = m_cnt + 32'd1;
    end else if (be) begin
      m_pv = 1'b1; m_pa = ba;
    end
    e.id   = {m_ce, m_pc};
    e.adel = m_ce && (m_pc % 4 != 0);
    e.en   = m_ce && !e.adel;
    e.addr = m_pc;
    e.cnt  = m_cnt;
    sb.push_back(e);
  endtask

  task automatic chk_pc(input string name, input logic [31:0] req);
    cmp(name, {1'b0, bus.if_to_id_bus[31:0]}, {1'b0, req});
  endtask

  initial begin
    logic        r, s0, be;
    logic [31:0] ba;
    rst        = 1'b0;
    bus.stall  = '0;
    bus.br_bus = '0;

    step(0, 0, 0, 32'h0);
    step(0, 1, 1, 32'h1234);
    chk_pc("reset_pc", 32'hBFBF_FFFC);
    cmp("reset_ce", {32'd0, bus.if_to_id_bus[32]}, 33'd0);

    step(1, 0, 0, 32'h0); chk_pc("first_fetch", 32'hBFC0_0000);
    cmp("first_ce", {32'd0, bus.if_to_id_bus[32]}, 33'd1);
    step(1, 0, 0, 32'h0); chk_pc("second_fetch", 32'hBFC0_0004);
    step(1, 0, 0, 32'h0); chk_pc("third_fetch", 32'hBFC0_0008);
    cmp("cnt_after_three", {1'b0, bus.fetch_cnt}, 33'd3);

    step(1, 0, 1, 32'hBFC0_0100); chk_pc("branch_taken", 32'hBFC0_0100);

    step(1, 1, 0, 32'h0);         chk_pc("hold_1", 32'hBFC0_0100);
    step(1, 1, 1, 32'hBFC0_0200); chk_pc("hold_2", 32'hBFC0_0100);
    step(1, 1, 0, 32'h0);
    cmp("hold_addr", {1'b0, bus.inst_sram_addr}, {1'b0, 32'hBFC0_0100});
    step(1, 0, 0, 32'h0);         chk_pc("pending_applied", 32'hBFC0_0200);
    step(1, 0, 0, 32'h0);         chk_pc("after_pending", 32'hBFC0_0204);

    step(1, 1, 1, 32'hBFC0_0300);
    step(1, 1, 1, 32'hBFC0_0400);
    step(1, 0, 0, 32'h0);         chk_pc("last_branch_wins", 32'hBFC0_0400);

    step(1, 1, 1, 32'hBFC0_0500);
    step(1, 0, 1, 32'hBFC0_0600); chk_pc("live_over_pending", 32'hBFC0_0600);

    step(1, 0, 1, 32'hBFC0_0702);
    cmp("adel_raised", {32'd0, bus.fetch_adel}, 33'd1);
    cmp("adel_no_read", {32'd0, bus.inst_sram_en}, 33'd0);
    cmp("adel_cnt_held", {1'b0, bus.fetch_cnt}, 33'd8);

    step(1, 1, 1, 32'hBFC0_0800);
    step(0, 1, 0, 32'h0);         chk_pc("reset_in_hold", 32'hBFBF_FFFC);
    step(1, 0, 0, 32'h0);         chk_pc("pending_discarded", 32'hBFC0_0000);

    step(1, 0, 1, 32'hFFFF_FFF8);
    step(1, 0, 0, 32'h0);         chk_pc("pre_wrap", 32'hFFFF_FFFC);
    step(1, 0, 0, 32'h0);         chk_pc("wrap", 32'h0000_0000);

    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) != 0);
      s0 = ($urandom_range(0, 2) == 0);
      be = ($urandom_range(0, 4) == 0);
      ba = $urandom;
      if ($urandom_range(0, 7) != 0) ba[1:0] = 2'b00;
      step(r, s0, be, ba);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
